// File: rtl/adc_pkt_rx.sv
// adc_pkt_rx: frames ADC capture packets from contiguous VALID runs and checks each packet's length.
// It also checks the inter-packet gap and the counter payload, and keeps saturating statistics.
module adc_pkt_rx #(
    parameter int DW  = 18,
    parameter int LCW = 12,
    parameter int SCW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           clr_i,
    input  logic [1:0]     cfg_len_type_i,
    input  logic [LCW-1:0] cfg_gap_i,
    input  logic           cfg_self_test_i,
    input  logic [DW-1:0]  adc_data_i,
    input  logic           adc_data_valid_i,
    output logic           pkt_done_o,
    output logic [LCW-1:0] pkt_len_o,
    output logic           pkt_len_ok_o,
    output logic [SCW-1:0] pkt_cnt_o,
    output logic [SCW-1:0] len_err_cnt_o,
    output logic [SCW-1:0] data_err_cnt_o,
    output logic [SCW-1:0] gap_err_cnt_o,
    output logic           busy_o
);
    // state | meaning
    // IDLE  | disabled or no packet since enable; the next packet skips the gap check
    // DATA  | inside a VALID run, counting words
    // GAP   | between packets, counting idle cycles
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_GAP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] word_cnt_q, word_cnt_d, gap_cnt_q, gap_cnt_d;
    logic [LCW-1:0] pkt_len_q, pkt_len_d, exp_len;
    logic [DW-1:0]  exp_q, exp_d;
    logic           seed_vld_q, seed_vld_d, pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
    logic [SCW-1:0] pkt_cnt_q, pkt_cnt_d, len_err_q, len_err_d;
    logic [SCW-1:0] data_err_q, data_err_d, gap_err_q, gap_err_d;
    logic           len_ok;

    function automatic logic [SCW-1:0] sat_s(input logic [SCW-1:0] v);
        return (v == '1) ? v : v + SCW'(1);
    endfunction

    function automatic logic [LCW-1:0] sat_l(input logic [LCW-1:0] v);
        return (v == '1) ? v : v + LCW'(1);
    endfunction

    assign exp_len = LCW'(216) << cfg_len_type_i;
    assign len_ok  = (word_cnt_q == exp_len);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (adc_data_valid_i)  state_d = S_DATA;
                S_DATA:  if (!adc_data_valid_i) state_d = S_GAP;
                S_GAP:   if (adc_data_valid_i)  state_d = S_DATA;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pkt_len_d  = pkt_len_q;
        pkt_ok_d   = pkt_ok_q;
        pkt_done_d = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        len_err_d  = len_err_q;
        data_err_d = data_err_q;
        gap_err_d  = gap_err_q;
        exp_d      = exp_q;
        seed_vld_d = seed_vld_q;
        if (en_i) begin
            case (state_q)
                S_IDLE: if (adc_data_valid_i) word_cnt_d = LCW'(1);
                S_DATA: begin
                    if (adc_data_valid_i) begin
                        word_cnt_d = sat_l(word_cnt_q);
                    end else begin
                        gap_cnt_d  = LCW'(1);
                        pkt_done_d = 1'b1;
                        pkt_len_d  = word_cnt_q;
                        pkt_ok_d   = len_ok;
                        pkt_cnt_d  = sat_s(pkt_cnt_q);
                        if (!len_ok) len_err_d = sat_s(len_err_q);
                    end
                end
                S_GAP: begin
                    if (adc_data_valid_i) begin
                        word_cnt_d = LCW'(1);
                        if (gap_cnt_q < cfg_gap_i) gap_err_d = sat_s(gap_err_q);
                    end else begin
                        gap_cnt_d = sat_l(gap_cnt_q);
                    end
                end
                default: ;
            endcase
            // Payload tracking follows the words themselves, so the seed spans packet boundaries.
            if (cfg_self_test_i && adc_data_valid_i) begin
                if (!seed_vld_q) begin
                    exp_d      = adc_data_i + DW'(1);
                    seed_vld_d = 1'b1;
                end else if (adc_data_i != exp_q) begin
                    data_err_d = sat_s(data_err_q);
                    exp_d      = adc_data_i + DW'(1);
                end else begin
                    exp_d = exp_q + DW'(1);
                end
            end
        end
        if (clr_i) begin
            pkt_len_d  = '0;
            pkt_ok_d   = 1'b0;
            pkt_cnt_d  = '0;
            len_err_d  = '0;
            data_err_d = '0;
            gap_err_d  = '0;
            seed_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pkt_len_q  <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_cnt_q  <= '0;
            len_err_q  <= '0;
            data_err_q <= '0;
            gap_err_q  <= '0;
            exp_q      <= '0;
            seed_vld_q <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pkt_len_q  <= pkt_len_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_done_q <= pkt_done_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_err_q  <= len_err_d;
            data_err_q <= data_err_d;
            gap_err_q  <= gap_err_d;
            exp_q      <= exp_d;
            seed_vld_q <= seed_vld_d;
        end
    end

    assign pkt_done_o     = pkt_done_q;
    assign pkt_len_o      = pkt_len_q;
    assign pkt_len_ok_o   = pkt_ok_q;
    assign pkt_cnt_o      = pkt_cnt_q;
    assign len_err_cnt_o  = len_err_q;
    assign data_err_cnt_o = data_err_q;
    assign gap_err_cnt_o  = gap_err_q;
    assign busy_o         = (state_q == S_DATA);
endmodule

// File: tb/tb_adc_pkt_rx.sv
// Testbench for adc_pkt_rx: table of packet scenarios with expected status/statistics,
// plus hand-written sequences for mid-packet reset, clr priority and enable drop.
module tb_adc_pkt_rx;
    localparam int DW  = 18;
    localparam int LCW = 12;
    localparam int SCW = 16;

    logic           clk_i = 1'b0;
    logic           rst_i, en_i, clr_i, cfg_self_test_i, adc_data_valid_i;
    logic [1:0]     cfg_len_type_i;
    logic [LCW-1:0] cfg_gap_i;
    logic [DW-1:0]  adc_data_i;
    logic           pkt_done_o, pkt_len_ok_o, busy_o;
    logic [LCW-1:0] pkt_len_o;
    logic [SCW-1:0] pkt_cnt_o, len_err_cnt_o, data_err_cnt_o, gap_err_cnt_o;

    adc_pkt_rx #(.DW(DW), .LCW(LCW), .SCW(SCW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
        .cfg_len_type_i(cfg_len_type_i), .cfg_gap_i(cfg_gap_i),
        .cfg_self_test_i(cfg_self_test_i), .adc_data_i(adc_data_i),
        .adc_data_valid_i(adc_data_valid_i), .pkt_done_o(pkt_done_o),
        .pkt_len_o(pkt_len_o), .pkt_len_ok_o(pkt_len_ok_o), .pkt_cnt_o(pkt_cnt_o),
        .len_err_cnt_o(len_err_cnt_o), .data_err_cnt_o(data_err_cnt_o),
        .gap_err_cnt_o(gap_err_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int ctr = 1;

    always @(negedge clk_i) if (pkt_done_o === 1'b1) done_cnt++;

    typedef struct {
        string name;
        int len_type, gap_cfg, self_test, npkts, words, gap_cyc, corrupt;
        int e_len, e_ok, e_pkt, e_lerr, e_derr, e_gerr;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // A corrupt index makes the source counter restart at 0 there: one bad word, then
    // the stream is a clean count again from the checker's resynchronised value.
    task automatic send_pkt(input int nw, input int corrupt);
        for (int i = 0; i < nw; i++) begin
            if (i == corrupt) ctr = 0;
            adc_data_i       = ctr[DW-1:0];
            adc_data_valid_i = 1'b1;
            ctr++;
            tick();
        end
        adc_data_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        adc_data_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic restart();
        adc_data_valid_i = 1'b0;
        en_i  = 1'b0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        en_i  = 1'b1;
        tick();
    endtask

    initial begin
        int d0;
        vecs[0] = '{"t1_432x3",    1, 4, 1, 3,  432, 6,  -1,  432, 1, 3, 0, 0, 0};
        vecs[1] = '{"t2_short",    0, 4, 1, 1,  215, 6,  -1,  215, 0, 1, 1, 0, 0};
        vecs[2] = '{"t3_corrupt",  0, 4, 1, 1,  216, 6,  100, 216, 1, 1, 0, 1, 0};
        vecs[3] = '{"t4_gap2",     0, 4, 1, 2,  216, 2,  -1,  216, 1, 2, 0, 0, 1};
        vecs[4] = '{"t4_gap4",     0, 4, 1, 2,  216, 4,  -1,  216, 1, 2, 0, 0, 0};
        vecs[5] = '{"len864",      2, 4, 1, 2,  864, 5,  -1,  864, 1, 2, 0, 0, 0};
        vecs[6] = '{"len1728_long",3, 4, 1, 1, 1729, 6,  -1, 1729, 0, 1, 1, 0, 0};
        vecs[7] = '{"no_selftest", 0, 4, 0, 1,  216, 6,  50,  216, 1, 1, 0, 0, 0};
        vecs[8] = '{"gap0_gap1",   1, 0, 1, 2,  432, 1,  -1,  432, 1, 2, 0, 0, 0};

        rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; cfg_len_type_i = 2'd0;
        cfg_gap_i = '0; cfg_self_test_i = 1'b0; adc_data_i = '0; adc_data_valid_i = 1'b0;
        tick(); tick();
        chk("rst_done", 32'(pkt_done_o), 0);
        chk("rst_len", 32'(pkt_len_o), 0);
        chk("rst_cnt", 32'(pkt_cnt_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;
        tick();

        foreach (vecs[k]) begin
            cfg_len_type_i  = 2'(vecs[k].len_type);
            cfg_gap_i       = LCW'(vecs[k].gap_cfg);
            cfg_self_test_i = vecs[k].self_test[0];
            restart();
            d0 = done_cnt;
            for (int p = 0; p < vecs[k].npkts; p++) begin
                send_pkt(vecs[k].words, (p == 0) ? vecs[k].corrupt : -1);
                idle((p == vecs[k].npkts - 1) ? 3 : vecs[k].gap_cyc);
            end
            chk({vecs[k].name, "_len"},   32'(pkt_len_o), vecs[k].e_len);
            chk({vecs[k].name, "_ok"},    32'(pkt_len_ok_o), vecs[k].e_ok);
            chk({vecs[k].name, "_pkt"},   32'(pkt_cnt_o), vecs[k].e_pkt);
            chk({vecs[k].name, "_lerr"},  32'(len_err_cnt_o), vecs[k].e_lerr);
            chk({vecs[k].name, "_derr"},  32'(data_err_cnt_o), vecs[k].e_derr);
            chk({vecs[k].name, "_gerr"},  32'(gap_err_cnt_o), vecs[k].e_gerr);
            chk({vecs[k].name, "_dones"}, done_cnt - d0, vecs[k].npkts);
            chk({vecs[k].name, "_busy"},  32'(busy_o), 0);
        end

        // Reset in the middle of a packet clears everything at once and emits no pkt_done.
        cfg_len_type_i = 2'd1; cfg_gap_i = LCW'(4); cfg_self_test_i = 1'b1;
        restart();
        send_pkt(432, 200);
        idle(6);
        chk("t5_pre_pkt", 32'(pkt_cnt_o), 1);
        chk("t5_pre_derr", 32'(data_err_cnt_o), 1);
        d0 = done_cnt;
        send_pkt(300, -1);
        chk("t5_busy_mid", 32'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk("t5_rst_pkt", 32'(pkt_cnt_o), 0);
        chk("t5_rst_len", 32'(pkt_len_o), 0);
        chk("t5_rst_ok", 32'(pkt_len_ok_o), 0);
        chk("t5_rst_derr", 32'(data_err_cnt_o), 0);
        chk("t5_rst_busy", 32'(busy_o), 0);
        tick(); tick();
        rst_i = 1'b0;
        idle(3);
        chk("t5_no_done", done_cnt - d0, 0);
        send_pkt(432, -1);
        idle(3);
        chk("t5_post_pkt", 32'(pkt_cnt_o), 1);
        chk("t5_post_ok", 32'(pkt_len_ok_o), 1);
        chk("t5_post_len", 32'(pkt_len_o), 432);
        chk("t5_post_gerr", 32'(gap_err_cnt_o), 0);

        // clr landing on the packet-end edge wins over the increments; the payload seed is dropped.
        cfg_len_type_i = 2'd0;
        restart();
        send_pkt(215, -1);
        idle(6);
        chk("t6_pre_pkt", 32'(pkt_cnt_o), 1);
        chk("t6_pre_lerr", 32'(len_err_cnt_o), 1);
        send_pkt(215, -1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("t6_done", 32'(pkt_done_o), 1);
        chk("t6_clr_pkt", 32'(pkt_cnt_o), 0);
        chk("t6_clr_lerr", 32'(len_err_cnt_o), 0);
        chk("t6_clr_len", 32'(pkt_len_o), 0);
        chk("t6_clr_ok", 32'(pkt_len_ok_o), 0);
        idle(6);
        ctr = 32'h3FFF0;
        send_pkt(216, -1);
        idle(3);
        chk("t6_wrap_derr", 32'(data_err_cnt_o), 0);
        chk("t6_wrap_pkt", 32'(pkt_cnt_o), 1);
        chk("t6_wrap_ok", 32'(pkt_len_ok_o), 1);

        // Dropping enable mid-packet discards it silently.
        restart();
        d0 = done_cnt;
        send_pkt(100, -1);
        chk("t7_busy", 32'(busy_o), 1);
        en_i = 1'b0;
        tick();
        chk("t7_idle", 32'(busy_o), 0);
        en_i = 1'b1;
        idle(4);
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_pkt", 32'(pkt_cnt_o), 0);
        chk("t7_lerr", 32'(len_err_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
